// File: rtl/dft_pkg.sv
// Shared types and helpers for the time-multiplexed 8-point DFT sequencer.
package dft_pkg;

    // pi/4 in Q.24 radians
    localparam logic [31:0] ANGLE_STEP = 32'd13176795;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] k;
        logic       last;
    } tag_t;

    function automatic logic [31:0] saturate(input logic signed [63:0] v);
        if (v > 64'sd2147483647) begin
            return 32'h7FFFFFFF;
        end else if (v < -64'sd2147483648) begin
            return 32'h80000000;
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/dft_tag_pipe.sv
// Enable-gated shift register that carries each issued rotation's bookkeeping
// alongside the CORDIC so results can be matched to their bin on return.
module dft_tag_pipe
    import dft_pkg::*;
#(
    parameter int unsigned DEPTH = 26
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_enable) begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/dft_sequencer.sv
// 8-point forward DFT controller: issues one (coeff, angle) rotation per cycle to a
// shared CORDIC, accumulates the returning x/y per bin and streams out saturated bins.
module dft_sequencer
    import dft_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned CORDIC_LAT = 26,
    parameter int unsigned ACC_W      = 35
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_start,
    input  logic [31:0] i_coeff_0,
    input  logic [31:0] i_coeff_1,
    input  logic [31:0] i_coeff_2,
    input  logic [31:0] i_coeff_3,
    input  logic [31:0] i_coeff_4,
    input  logic [31:0] i_coeff_5,
    input  logic [31:0] i_coeff_6,
    input  logic [31:0] i_coeff_7,
    output logic [31:0] o_cordic_x_in,
    output logic [31:0] o_cordic_angle,
    output logic        o_cordic_en,
    input  logic [31:0] i_cordic_x_out,
    input  logic [31:0] i_cordic_y_out,
    output logic        o_busy,
    output logic        o_out_valid,
    output logic [2:0]  o_out_bin,
    output logic [31:0] o_out_re,
    output logic [31:0] o_out_im,
    output logic        o_done
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = 2 * IDX_W;

    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [31:0]             r_coeff [N];
    logic [IDX_W-1:0]        w_k, w_j, w_m, w_neg_m;
    logic                    w_issue, w_accept;
    tag_t                    w_tag_in, w_tag_out;
    logic signed [ACC_W-1:0] r_acc_re, r_acc_im, w_sum_re, w_sum_im;
    logic                    r_out_valid, r_done;
    logic [2:0]              r_out_bin;
    logic [31:0]             r_out_re, r_out_im;

    assign w_accept = i_enable && (r_state == IDLE) && i_start;
    assign w_issue  = (r_state == ISSUE);
    assign w_k      = r_cnt[CNT_W-1:IDX_W];
    assign w_j      = r_cnt[IDX_W-1:0];
    assign w_m      = IDX_W'(w_j * w_k);
    // (8 - m) mod 8 gives 0 for m = 0, which yields angle 0 with no special case
    assign w_neg_m  = IDX_W'(0) - w_m;

    assign o_cordic_x_in  = w_issue ? r_coeff[w_j] : '0;
    assign o_cordic_angle = w_issue ? 32'(w_neg_m) * ANGLE_STEP : '0;
    assign o_cordic_en    = i_enable;

    assign w_tag_in.valid = w_issue;
    assign w_tag_in.k     = w_k;
    assign w_tag_in.last  = (w_j == IDX_W'(N - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_next = ISSUE;
            ISSUE:   if (r_cnt == CNT_W'(N * N - 1)) w_state_next = DRAIN;
            DRAIN:   if (w_tag_out.valid && w_tag_out.last && w_tag_out.k == 3'(N - 1))
                         w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (i_enable) begin
            r_state <= w_state_next;
            r_done  <= (r_state == DONE);
            r_cnt   <= w_issue ? r_cnt + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_coeff[i] <= '0;
            end
        end else if (w_accept) begin
            r_coeff[0] <= i_coeff_0;
            r_coeff[1] <= i_coeff_1;
            r_coeff[2] <= i_coeff_2;
            r_coeff[3] <= i_coeff_3;
            r_coeff[4] <= i_coeff_4;
            r_coeff[5] <= i_coeff_5;
            r_coeff[6] <= i_coeff_6;
            r_coeff[7] <= i_coeff_7;
        end
    end

    dft_tag_pipe #(
        .DEPTH (CORDIC_LAT)
    ) u_tag_pipe (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_tag    (w_tag_in),
        .o_tag    (w_tag_out)
    );

    assign w_sum_re = r_acc_re + {{(ACC_W-32){i_cordic_x_out[31]}}, i_cordic_x_out};
    assign w_sum_im = r_acc_im + {{(ACC_W-32){i_cordic_y_out[31]}}, i_cordic_y_out};

    // The bin result includes the term returning with the last tag, so the accumulator
    // can clear in the same cycle and bin k+1 starts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else if (i_enable) begin
            r_out_valid <= 1'b0;
            if (w_tag_out.valid) begin
                if (w_tag_out.last) begin
                    r_out_re    <= saturate(64'(w_sum_re));
                    r_out_im    <= saturate(64'(w_sum_im));
                    r_out_bin   <= w_tag_out.k;
                    r_out_valid <= 1'b1;
                    r_acc_re    <= '0;
                    r_acc_im    <= '0;
                end else begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                end
            end
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_bin   = r_out_bin;
    assign o_out_re    = r_out_re;
    assign o_out_im    = r_out_im;
    assign o_done      = r_done;

endmodule

// File: tb/tb_dft_sequencer.sv
// Bench for dft_sequencer: ideal-rotator model on the CORDIC port, floating-point DFT
// reference for the expected bins, directed and random runs with stalls and resets.
module tb_dft_sequencer;
    import dft_pkg::*;

    localparam int  LAT = 26;
    localparam int  TOL = 16;
    localparam real PI  = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [31:0] c_in [8];
    logic [31:0] cordic_x_in, cordic_angle;
    logic        cordic_en, busy, out_valid, done;
    logic [2:0]  out_bin;
    logic [31:0] out_re, out_im;

    int n_checks = 0;
    int n_errors = 0;
    int ref_c [8];
    int exp_re [8];
    int exp_im [8];
    int q_bin [$];
    int q_re [$];
    int q_im [$];
    int cx_pipe [LAT];
    int cy_pipe [LAT];

    always #5 clk = ~clk;

    dft_sequencer #(
        .N          (8),
        .CORDIC_LAT (LAT),
        .ACC_W      (35)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_start        (start),
        .i_coeff_0      (c_in[0]),
        .i_coeff_1      (c_in[1]),
        .i_coeff_2      (c_in[2]),
        .i_coeff_3      (c_in[3]),
        .i_coeff_4      (c_in[4]),
        .i_coeff_5      (c_in[5]),
        .i_coeff_6      (c_in[6]),
        .i_coeff_7      (c_in[7]),
        .o_cordic_x_in  (cordic_x_in),
        .o_cordic_angle (cordic_angle),
        .o_cordic_en    (cordic_en),
        .i_cordic_x_out (cx_pipe[LAT-1]),
        .i_cordic_y_out (cy_pipe[LAT-1]),
        .o_busy         (busy),
        .o_out_valid    (out_valid),
        .o_out_bin      (out_bin),
        .o_out_re       (out_re),
        .o_out_im       (out_im),
        .o_done         (done)
    );

    function automatic int rnd(input real v);
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    function automatic int clamp(input real v);
        if (v > 2147483647.0) return 32'sh7FFFFFFF;
        if (v < -2147483648.0) return 32'sh80000000;
        return rnd(v);
    endfunction

    // Ideal gain-compensated rotator; angles are treated as multiples of pi/4.
    function automatic int rot(input logic [31:0] x, input logic [31:0] ang, input bit want_y);
        int  m;
        real a, xr;
        m  = int'(ang / ANGLE_STEP);
        a  = real'(m) * PI / 4.0;
        xr = $itor($signed(x));
        return rnd(want_y ? xr * $sin(a) : xr * $cos(a));
    endfunction

    always @(posedge clk) begin
        if (enable) begin
            for (int i = LAT - 1; i > 0; i--) begin
                cx_pipe[i] <= cx_pipe[i-1];
                cy_pipe[i] <= cy_pipe[i-1];
            end
            cx_pipe[0] <= rot(cordic_x_in, cordic_angle, 1'b0);
            cy_pipe[0] <= rot(cordic_x_in, cordic_angle, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (enable && out_valid) begin
            q_bin.push_back(int'(out_bin));
            q_re.push_back(int'(out_re));
            q_im.push_back(int'(out_im));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input int expv);
        logic signed [63:0] d;
        logic               ok;
        d  = 64'($signed(obs)) - 64'(expv);
        ok = (d <= 64'(TOL)) && (d >= -64'(TOL));
        n_checks++;
        assert (ok === 1'b1) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d (+-%0d)", tag, $signed(obs), expv, TOL);
        end
    endtask

    task automatic compute_ref();
        for (int k = 0; k < 8; k++) begin
            real sr, si, a;
            sr = 0.0;
            si = 0.0;
            for (int j = 0; j < 8; j++) begin
                a  = 2.0 * PI * real'(j * k) / 8.0;
                sr = sr + $itor(ref_c[j]) * $cos(a);
                si = si - $itor(ref_c[j]) * $sin(a);
            end
            exp_re[k] = clamp(sr);
            exp_im[k] = clamp(si);
        end
    endtask

    // Called #1 after a posedge. cyc counts enabled cycles with start accepted at cycle 0.
    task automatic do_run(input string name, input int stall_at, input int stall_len,
                          input bit dup, input int abort_at);
        int cyc, wall, stalled, done_cyc, done_wall;
        bit got_done, aborted;
        q_bin.delete();
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < 8; i++) ref_c[i] = int'(c_in[i]);
        compute_ref();
        cyc = 0; wall = 0; stalled = 0; got_done = 0; aborted = 0;
        done_cyc = -1; done_wall = -1;
        while (!got_done && wall < 400) begin
            enable = !(stall_len > 0 && cyc == stall_at && stalled < stall_len);
            if (!enable) stalled++;
            start = (cyc == 0) || (dup && enable && (cyc == 5 || cyc == 70));
            if (dup && enable && (cyc == 5 || cyc == 30)) begin
                for (int i = 0; i < 8; i++) c_in[i] = $urandom;
            end
            if (abort_at > 0 && cyc == abort_at) begin
                rst_n   = 1'b0;
                aborted = 1;
                break;
            end
            @(negedge clk);
            if (cyc == 1 && enable) chk({name, ".busy_c1"}, 64'(busy), 64'(1));
            if (!enable && cyc == 35) chk({name, ".held_valid"}, 64'(out_valid), 64'(1));
            if (done && enable) begin
                got_done  = 1;
                done_cyc  = cyc;
                done_wall = wall;
                chk({name, ".busy_at_done"}, 64'(busy), 64'(0));
            end
            @(posedge clk);
            #1;
            if (enable) cyc++;
            wall++;
        end
        start  = 1'b0;
        enable = 1'b1;
        if (!aborted) begin
            chk({name, ".done_seen"}, 64'(got_done), 64'(1));
            chk({name, ".done_cycle"}, 64'(done_cyc), 64'(66 + LAT));
            chk({name, ".done_wall"}, 64'(done_wall), 64'(66 + LAT + stall_len));
            chk({name, ".n_bins"}, 64'(q_bin.size()), 64'(8));
            for (int k = 0; k < 8 && k < q_bin.size(); k++) begin
                chk($sformatf("%s.bin%0d", name, k), 64'(q_bin[k]), 64'(k));
                chk_near($sformatf("%s.re%0d", name, k), q_re[k], exp_re[k]);
                chk_near($sformatf("%s.im%0d", name, k), q_im[k], exp_im[k]);
            end
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, ".busy"}, 64'(busy), 64'(0));
        chk({name, ".out_valid"}, 64'(out_valid), 64'(0));
        chk({name, ".done"}, 64'(done), 64'(0));
        chk({name, ".out_bin"}, 64'(out_bin), 64'(0));
        chk({name, ".out_re"}, 64'(out_re), 64'(0));
        chk({name, ".out_im"}, 64'(out_im), 64'(0));
        chk({name, ".x_in"}, 64'(cordic_x_in), 64'(0));
        chk({name, ".angle"}, 64'(cordic_angle), 64'(0));
        chk({name, ".cordic_en"}, 64'(cordic_en), 64'(enable));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) c_in[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) c_in[i] = (i == 0) ? 32'h01000000 : 32'h0;
        do_run("impulse", 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) c_in[i] = 32'h01000000;
        do_run("dc", 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) c_in[i] = (i == 1) ? 32'h01000000 : 32'h0;
        do_run("tone", 0, 0, 0, 0);
        chk("tone.im2_exact_ref", 64'(exp_im[2]), 64'(32'shFF000000));

        for (int i = 0; i < 8; i++) c_in[i] = 32'h7F000000;
        do_run("sat", 0, 0, 0, 0);
        if (q_re.size() > 0) chk("sat.re0", 64'(q_re[0]), 64'(32'sh7FFFFFFF));

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) c_in[i] = 32'(int'($urandom) >>> 2);
            do_run($sformatf("rand%0d", r), 0, 0, 0, 0);
        end

        for (int i = 0; i < 8; i++) c_in[i] = 32'(int'($urandom) >>> 3);
        do_run("stall_issue", 20, 10, 0, 0);
        do_run("stall_valid", 35, 3, 0, 0);

        for (int i = 0; i < 8; i++) c_in[i] = 32'(int'($urandom) >>> 3);
        do_run("dup_start", 0, 0, 1, 0);

        for (int i = 0; i < 8; i++) c_in[i] = 32'(int'($urandom) >>> 3);
        do_run("abort", 0, 0, 0, 40);
        #1;
        chk_zero_outputs("abort_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_bin.delete();
        q_re.delete();
        q_im.delete();
        repeat (40) @(posedge clk);
        #1;
        chk("abort.stray_valid", 64'(q_bin.size()), 64'(0));
        for (int i = 0; i < 8; i++) c_in[i] = (i == 0) ? 32'h01000000 : 32'h0;
        do_run("after_abort", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
